// File: rtl/data_hs_serializer.sv
// data_hs_serializer: D-PHY HS lane byte serializer with Serial_End/underrun handshake and trail drive.
// Optional PRBS7 test source when HS_SER_PRBS_EN is defined.
module data_hs_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Serial_En,
  input  logic             Serial_Valid,
  input  logic [WIDTH-1:0] HS_prll_data,
  input  logic             Trail,
  input  logic             Trail_sel,
  input  logic             prbs_mode,
  output logic             hs_dout,
  output logic             Serial_End,
  output logic             hs_active,
  output logic             underrun
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN  = CW'(WIDTH - 2);
  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_shreg, w_shreg;
  logic [CW-1:0]    r_bitcnt, w_bitcnt;
  logic             r_last, w_last;
  logic             r_dout, w_dout;
  logic             r_end, w_end;
  logic             r_active, w_active;
  logic             r_under, w_under;
  logic             w_load, w_adv, w_pr, w_pr_go, w_nbit;
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] d);
    return LSB_FIRST ? d >> 1 : d << 1;
  endfunction
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return LSB_FIRST ? d[0] : d[WIDTH-1];
  endfunction
`ifdef HS_SER_PRBS_EN
  localparam logic [6:0] SEED = 7'h7F;
  logic [6:0] r_lfsr, w_lfsr;
  logic       r_prbs, w_prbs;
  assign w_pr   = r_prbs;
  assign w_nbit = r_prbs ? r_lfsr[6] : first_bit(r_shreg);
`else
  logic w_unused;
  assign w_unused = prbs_mode;
  assign w_pr     = 1'b0;
  assign w_nbit   = first_bit(r_shreg);
`endif
  always_comb begin
    w_state  = r_state;
    w_shreg  = r_shreg;
    w_bitcnt = r_bitcnt;
    w_last   = r_last;
    w_dout   = IDLE_LEVEL;
    w_end    = 1'b0;
    w_active = 1'b0;
    w_under  = 1'b0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    w_pr_go  = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = Serial_En & Serial_Valid;
`ifdef HS_SER_PRBS_EN
        w_pr_go = Serial_En & prbs_mode;
`endif
      end
      SHIFT: begin
        if (r_bitcnt != LAST) begin
          w_adv   = Serial_En | w_pr;
          w_state = w_adv ? SHIFT : IDLE;
        end else if (w_pr) begin
          w_pr_go = Serial_En & prbs_mode;
          w_state = w_pr_go ? SHIFT : IDLE;
        end else begin
          // byte boundary: abort, then back-to-back data, then trail, else underrun
          w_last   = r_dout;
          w_load   = Serial_En & Serial_Valid;
          w_state  = !Serial_En ? IDLE : Serial_Valid ? SHIFT : Trail_sel ? TRAIL : IDLE;
          w_under  = Serial_En & !Serial_Valid & !Trail_sel;
          w_active = (w_state == TRAIL);
          w_dout   = w_active ? ~r_dout : IDLE_LEVEL;
        end
      end
      TRAIL: begin
        w_active = Trail & Serial_En;
        w_dout   = w_active ? ~r_last : IDLE_LEVEL;
        w_state  = w_active ? TRAIL : IDLE;
      end
      default: w_state = IDLE;
    endcase
    if (w_adv) begin
      w_dout   = w_nbit;
      w_shreg  = shift_word(r_shreg);
      w_bitcnt = r_bitcnt + 1'b1;
      w_end    = (r_bitcnt == PEN);
      w_active = 1'b1;
    end
    if (w_load) begin
      w_state  = SHIFT;
      w_shreg  = shift_word(HS_prll_data);
      w_bitcnt = '0;
      w_dout   = first_bit(HS_prll_data);
      w_active = 1'b1;
    end
`ifdef HS_SER_PRBS_EN
    w_lfsr = r_lfsr;
    w_prbs = r_prbs;
    if (w_pr_go) begin
      w_state  = SHIFT;
      w_bitcnt = '0;
      w_dout   = r_lfsr[6];
      w_active = 1'b1;
      w_prbs   = 1'b1;
    end
    if (w_pr_go | (w_adv & r_prbs))
      w_lfsr = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    if (w_state == IDLE) begin
      w_lfsr = SEED;
      w_prbs = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_last   <= 1'b0;
      r_dout   <= IDLE_LEVEL;
      r_end    <= 1'b0;
      r_active <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_shreg  <= w_shreg;
      r_bitcnt <= w_bitcnt;
      r_last   <= w_last;
      r_dout   <= w_dout;
      r_end    <= w_end;
      r_active <= w_active;
      r_under  <= w_under;
    end
  end
`ifdef HS_SER_PRBS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
      r_prbs <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr;
      r_prbs <= w_prbs;
    end
  end
`endif
  assign hs_dout    = r_dout;
  assign Serial_End = r_end;
  assign hs_active  = r_active;
  assign underrun   = r_under;
endmodule
